// File: rtl/rv_pipe_controller_if.sv
// Control/hazard bus between the RV32I pipeline controller and the 5-stage datapath.
// The datapath side (master) supplies the D instruction and E comparison flags.
interface rv_pipe_controller_if;
    logic [31:0] InstrD;
    logic        ZeroE;
    logic        LtE;
    logic        LtuE;
    logic [2:0]  ImmSrcD;
    logic [3:0]  ALUControlE;
    logic        ALUSrcAE;
    logic        ALUSrcBE;
    logic        PCSrcE;
    logic        PCTargetSrcE;
    logic [1:0]  ForwardAE;
    logic [1:0]  ForwardBE;
    logic        MemWriteM;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [4:0]  RdW;
    logic        StallF;
    logic        StallD;
    logic        FlushD;
    logic        FlushE;

    modport master (
        output InstrD, ZeroE, LtE, LtuE,
        input  ImmSrcD, ALUControlE, ALUSrcAE, ALUSrcBE, PCSrcE, PCTargetSrcE,
               ForwardAE, ForwardBE, MemWriteM, RegWriteW, ResultSrcW, RdW,
               StallF, StallD, FlushD, FlushE
    );

    modport slave (
        input  InstrD, ZeroE, LtE, LtuE,
        output ImmSrcD, ALUControlE, ALUSrcAE, ALUSrcBE, PCSrcE, PCTargetSrcE,
               ForwardAE, ForwardBE, MemWriteM, RegWriteW, ResultSrcW, RdW,
               StallF, StallD, FlushD, FlushE
    );
endinterface

// File: rtl/rv_pipe_controller.sv
// Pipelined RV32I controller: D-stage decode, E/M/W control slots, branch
// resolution in E and the hazard unit (forwarding, load-use stall, flush).
module rv_pipe_controller #(
    parameter bit FWD_EN = 1'b1
) (
    input logic                 clk,
    input logic                 reset,
    rv_pipe_controller_if.slave bus
);
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic       alu_src_a;
        logic       alu_src_b;
        logic       pc_target_src;
        logic [3:0] alu_ctrl;
        logic [2:0] funct3;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
    } ex_slot_t;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic [4:0] rd;
    } mem_slot_t;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic [4:0] rd;
    } wb_slot_t;

    ex_slot_t  dec, ex;
    mem_slot_t mem;
    wb_slot_t  wb;

    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic [4:0] rs1_d, rs2_d;
    logic [2:0] imm_src;
    logic [3:0] alu_rr;
    logic       taken, pc_src, stall, flush_e;
    logic       hit_e, hit_m;
    logic       unused_instr_bits;

    assign op       = bus.InstrD[6:0];
    assign funct3   = bus.InstrD[14:12];
    assign funct7b5 = bus.InstrD[30];
    assign rs1_d    = bus.InstrD[19:15];
    assign rs2_d    = bus.InstrD[24:20];
    assign unused_instr_bits = ^{bus.InstrD[31], bus.InstrD[29:25]};

    // funct7b5 selects sub only for register-register ops; addi ignores it
    always_comb begin
        alu_rr = ALU_ADD;
        case (funct3)
            3'b000:  alu_rr = (op == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_rr = ALU_SLL;
            3'b010:  alu_rr = ALU_SLT;
            3'b011:  alu_rr = ALU_SLTU;
            3'b100:  alu_rr = ALU_XOR;
            3'b101:  alu_rr = funct7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  alu_rr = ALU_OR;
            default: alu_rr = ALU_AND;
        endcase
    end

    always_comb begin
        dec        = '0;
        imm_src    = 3'b000;
        dec.funct3 = funct3;
        dec.rs1    = rs1_d;
        dec.rs2    = rs2_d;
        dec.rd     = bus.InstrD[11:7];
        case (op)
            OP_LOAD: begin
                dec.alu_src_b  = 1'b1;
                dec.result_src = 2'b01;
                dec.reg_write  = 1'b1;
            end
            OP_STORE: begin
                imm_src       = 3'b001;
                dec.alu_src_b = 1'b1;
                dec.mem_write = 1'b1;
            end
            OP_R: begin
                dec.alu_ctrl  = alu_rr;
                dec.reg_write = 1'b1;
            end
            OP_IALU: begin
                dec.alu_ctrl  = alu_rr;
                dec.alu_src_b = 1'b1;
                dec.reg_write = 1'b1;
            end
            OP_BRANCH: begin
                imm_src      = 3'b010;
                dec.alu_ctrl = ALU_SUB;
                dec.branch   = 1'b1;
            end
            OP_JAL: begin
                imm_src        = 3'b011;
                dec.jump       = 1'b1;
                dec.result_src = 2'b10;
                dec.reg_write  = 1'b1;
            end
            OP_JALR: begin
                dec.alu_src_b     = 1'b1;
                dec.jump          = 1'b1;
                dec.pc_target_src = 1'b1;
                dec.result_src    = 2'b10;
                dec.reg_write     = 1'b1;
            end
            OP_LUI: begin
                imm_src        = 3'b100;
                dec.result_src = 2'b11;
                dec.reg_write  = 1'b1;
            end
            OP_AUIPC: begin
                imm_src       = 3'b100;
                dec.alu_src_a = 1'b1;
                dec.alu_src_b = 1'b1;
                dec.reg_write = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        case (ex.funct3)
            3'b000:  taken = bus.ZeroE;
            3'b001:  taken = ~bus.ZeroE;
            3'b100:  taken = bus.LtE;
            3'b101:  taken = ~bus.LtE;
            3'b110:  taken = bus.LtuE;
            3'b111:  taken = ~bus.LtuE;
            default: taken = 1'b0;
        endcase
    end

    assign pc_src = (ex.branch & taken) | ex.jump;

    function automatic logic [1:0] fwd_sel(input logic [4:0] src, input mem_slot_t m,
                                           input wb_slot_t w);
        if (m.reg_write && m.rd != 5'd0 && m.rd == src)      return 2'b10;
        else if (w.reg_write && w.rd != 5'd0 && w.rd == src) return 2'b01;
        else                                                 return 2'b00;
    endfunction

    // Raw rs fields are compared even for formats that do not read them
    assign hit_e = (ex.rd != 5'd0) && (ex.rd == rs1_d || ex.rd == rs2_d);
    assign hit_m = (mem.rd != 5'd0) && (mem.rd == rs1_d || mem.rd == rs2_d);
    assign stall = FWD_EN ? (ex.result_src == 2'b01 && hit_e)
                          : ((ex.reg_write && hit_e) || (mem.reg_write && hit_m));
    assign flush_e = stall | pc_src;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex  <= '0;
            mem <= '0;
            wb  <= '0;
        end else begin
            ex  <= flush_e ? '0 : dec;
            mem <= '{reg_write: ex.reg_write, result_src: ex.result_src,
                     mem_write: ex.mem_write, rd: ex.rd};
            wb  <= '{reg_write: mem.reg_write, result_src: mem.result_src, rd: mem.rd};
        end
    end

    assign bus.ImmSrcD      = imm_src;
    assign bus.ALUControlE  = ex.alu_ctrl;
    assign bus.ALUSrcAE     = ex.alu_src_a;
    assign bus.ALUSrcBE     = ex.alu_src_b;
    assign bus.PCSrcE       = pc_src;
    assign bus.PCTargetSrcE = ex.pc_target_src;
    assign bus.ForwardAE    = FWD_EN ? fwd_sel(ex.rs1, mem, wb) : 2'b00;
    assign bus.ForwardBE    = FWD_EN ? fwd_sel(ex.rs2, mem, wb) : 2'b00;
    assign bus.MemWriteM    = mem.mem_write;
    assign bus.RegWriteW    = wb.reg_write;
    assign bus.ResultSrcW   = wb.result_src;
    assign bus.RdW          = wb.rd;
    assign bus.StallF       = stall;
    assign bus.StallD       = stall;
    assign bus.FlushD       = pc_src;
    assign bus.FlushE       = flush_e;
endmodule

// File: doc/rv_pipe_controller.md
# rv_pipe_controller

Parametrised successor to the single-cycle RV32I controller. It decodes the D-stage instruction and carries its control word through registered E/M/W pipeline slots. It also resolves branches in E for the full conditional-branch set plus JAL/JALR/LUI/AUIPC, and contains the hazard unit: operand forwarding, load-use stall and control-transfer flush. It sits between the IF/ID register and the 5-stage datapath and drives all datapath muxes, write enables and pipeline stall/flush lines.

## Interface
- FWD_EN, 1, 1: E-stage forwarding from M/W enabled; 0: no forwarding, RAW hazards resolved by stalling only.
- clk  in  1  clock, all registers rising-edge.
- reset  in  1  asynchronous, active-high; clears every pipeline control register.
- InstrD  in  32  instruction in D; rs1=[19:15], rs2=[24:20], rd=[11:7], funct3=[14:12], funct7b5=[30], op=[6:0].
- ZeroE  in  1  ALU result zero (E).
- LtE  in  1  signed rs1<rs2 (E).
- LtuE  in  1  unsigned rs1<rs2 (E).
- ImmSrcD  out  3  000 I, 001 S, 010 B, 011 J, 100 U (combinational, D).
- ALUControlE  out  4  0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu, 7 sll, 8 srl, 9 sra.
- ALUSrcAE  out  1  0 rs1, 1 PC (AUIPC).
- ALUSrcBE  out  1  0 rs2, 1 ImmExt.
- PCSrcE  out  1  redirect PC this cycle.
- PCTargetSrcE  out  1  0 PC+imm, 1 ALU result (JALR).
- ForwardAE, ForwardBE  out  2 each  00 register file, 01 W result, 10 M ALU result.
- MemWriteM  out  1  store enable (M).
- RegWriteW  out  1  register write enable (W).
- ResultSrcW  out  2  00 ALU, 01 memory, 10 PC+4, 11 ImmExt.
- RdW  out  5  destination register (W).
- StallF, StallD  out  1 each  hold PC / IF-ID register.
- FlushD, FlushE  out  1 each  clear IF-ID / ID-EX register.

## Operation
- Main decode by op: 0000011 load (I, add, B=imm, Result 01, RegWrite); 0100011 store (S, add, MemWrite); 0110011 R (RegWrite); 0010011 I-ALU (I, B=imm, RegWrite); 1100011 branch (B, sub, Branch); 1101111 JAL (J, Jump, Result 10, RegWrite); 1100111 JALR (I, add, B=imm, Jump, PCTargetSrc=1, Result 10, RegWrite); 0110111 LUI (U, Result 11, RegWrite); 0010111 AUIPC (U, add, A=PC, B=imm, RegWrite). Any other op: all controls 0 (bubble).
- ALU decode for R/I-ALU by funct3: 000 add (sub if R and funct7b5), 001 sll, 010 slt, 011 sltu, 100 xor, 101 srl/sra by funct7b5, 110 or, 111 and.
- Control word plus funct3, rs1, rs2 and rd registered D→E; RegWrite, ResultSrc, MemWrite and rd E→M; RegWrite, ResultSrc and rd M→W.
- Branch taken by funct3E: 000 ZeroE, 001 !ZeroE, 100 LtE, 101 !LtE, 110 LtuE, 111 !LtuE; 010/011 never taken. PCSrcE = BranchE&taken | JumpE.
- Forwarding (FWD_EN=1), per source X in {rs1E, rs2E}: 10 if RegWriteM & RdM!=0 & RdM==X; else 01 if RegWriteW & RdW!=0 & RdW==X; else 00. M has priority. With FWD_EN=0 the outputs are constant 00.
- Stall condition: FWD_EN=1: ResultSrcE==01 & RdE!=0 & RdE∈{rs1D,rs2D}. FWD_EN=0: (RegWriteE & RdE!=0 & RdE∈{rs1D,rs2D}) | (same for M). Comparison uses the raw fields, irrespective of whether the instruction reads them. The register file is write-before-read, so W never stalls.
- StallF=StallD=stall; FlushD=PCSrcE; FlushE=stall|PCSrcE.
- FlushE clears the D→E slot to bubble: all controls 0 and rd 0. The D→E slot otherwise always loads. E→M and M→W always load.

## Timing
- Reset: all slots are bubbles. Consequently PCSrcE, MemWriteM, RegWriteW, Stall*, Flush* are 0, ForwardAE/BE are 00, and RdW is 0.
- Decode → E outputs: 1 cycle; → MemWriteM: 2 cycles; → RegWriteW: 3 cycles.
- Branch penalty 2 cycles (D and E flushed). Load-use penalty 1 bubble.
- Stall and PCSrcE in the same cycle: the flush wins. FlushE and FlushD both assert; the stalled D instruction is discarded.
- Reset asserted mid-pipeline clears in-flight stores and writes immediately (asynchronous).

## Test plan
- Reset, then `add x3,x1,x2` → 1 cycle later ALUControlE=0000, ALUSrcBE=0; 3 cycles later RegWriteW=1, RdW=3, ResultSrcW=00.
- `add x5,…` followed by `sub x6,x5,x7` → with the sub in E, ForwardAE=10; with a one-instruction gap, ForwardAE=01. Writes to x0 never forward.
- `lw x5,0(x1)` then `add x6,x5,x2` → StallF=StallD=FlushE=1 for exactly one cycle, then ForwardAE=01.
- `blt` with LtE=1 → PCSrcE=1, FlushD=FlushE=1. With LtE=0, nothing asserts. `bgeu` with LtuE=0 → taken.
- `jalr x1,4(x2)` → PCSrcE=1, PCTargetSrcE=1; later ResultSrcW=10. `lui` → ResultSrcW=11. Unknown op 0000000 → no writes.
- FWD_EN=0: add followed by a dependent add → stall 2 cycles; ForwardAE/BE are 00 throughout.
